// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared types and helpers for the pulse stretcher.
//   chan_state_t : per-channel FSM state (IDLE / ON / GAP)
//   clog2_min1   : ceiling log2 for counter sizing, never less than 1 bit
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } chan_state_t;

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// pulse_stretcher_channel: one LED channel of the pulse stretcher.
//   clk              : clock
//   rst_n            : asynchronous active-low reset
//   tick             : shared sample tick, one cycle wide
//   event_signal     : synchronous event strobe, any length
//   stretched_signal : registered LED drive, high while the channel is ON
//                      (one cycle behind the FSM state)
module pulse_stretcher_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned on_count_max      = 150,
  parameter int unsigned gap_count_max     = 50,
  parameter int unsigned on_counter_width  = clog2_min1(on_count_max + 1),
  parameter int unsigned gap_counter_width = clog2_min1(gap_count_max + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic event_signal,
  output logic stretched_signal
);

  // One counter serves both the ON and GAP phases.
  localparam int unsigned CNT_W = (on_counter_width > gap_counter_width) ?
                                  on_counter_width : gap_counter_width;
  localparam bit GAP_EN = (gap_count_max != 0);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(on_count_max - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = GAP_EN ? CNT_W'(gap_count_max - 1) : '0;

  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      pending          <= 1'b0;
      stretched_signal <= 1'b0;
    end else begin
      stretched_signal <= (state == ST_ON);
      unique case (state)
        ST_IDLE: begin
          if (event_signal) begin
            state <= ST_ON;
            cnt   <= '0;
          end
        end
        ST_ON: begin
          // A fresh event restarts the on-period before expiry is considered.
          if (event_signal) begin
            cnt <= '0;
          end else if (tick) begin
            if (cnt == ON_LAST) begin
              cnt   <= '0;
              state <= GAP_EN ? ST_GAP : ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick && (cnt == GAP_LAST)) begin
            cnt     <= '0;
            pending <= 1'b0;
            state   <= (pending || event_signal) ? ST_ON : ST_IDLE;
          end else begin
            // Any number of events during the gap fold into one later blink.
            if (event_signal) pending <= 1'b1;
            if (tick)         cnt     <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches short event strobes into LED pulses with a
// guaranteed minimum on-time and a forced off-gap between blinks.
//   clk              : sole clock
//   rst_n            : asynchronous active-low reset
//   event_signal     : [width] synchronous event strobes
//   stretched_signal : [width] registered, stretched LED drive
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned width                  = 1,
  parameter int unsigned sample_count_max       = 25000,
  parameter int unsigned on_count_max           = 150,
  parameter int unsigned gap_count_max          = 50,
  parameter int unsigned wrapping_counter_width = clog2_min1(sample_count_max),
  parameter int unsigned on_counter_width       = clog2_min1(on_count_max + 1),
  parameter int unsigned gap_counter_width      = clog2_min1(gap_count_max + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] event_signal,
  output logic [width-1:0] stretched_signal
);

  localparam logic [wrapping_counter_width-1:0] TICK_LAST =
    wrapping_counter_width'(sample_count_max - 1);

  logic [wrapping_counter_width-1:0] tick_cnt;
  logic                              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_chan
    pulse_stretcher_channel #(
      .on_count_max      (on_count_max),
      .gap_count_max     (gap_count_max),
      .on_counter_width  (on_counter_width),
      .gap_counter_width (gap_counter_width)
    ) u_chan (
      .clk              (clk),
      .rst_n            (rst_n),
      .tick             (tick),
      .event_signal     (event_signal[i]),
      .stretched_signal (stretched_signal[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] event_signal = '0;
  logic [1:0] stretched_signal;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  pulse_stretcher #(
    .width            (2),
    .sample_count_max (4),
    .on_count_max     (3),
    .gap_count_max    (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .event_signal     (event_signal),
    .stretched_signal (stretched_signal)
  );

  always #5 clk = ~clk;

  function automatic logic rng(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  task automatic check_out(input string tag, input int edge_i, input logic [1:0] expected);
    checks++;
    assert (stretched_signal === expected)
    else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_i, stretched_signal, expected);
    end
  endtask

  // Drive the events sampled at edge e, queue the output expected after it,
  // then compare once the edge has passed.
  task automatic step(input string tag, input int e, input logic [1:0] ev, input logic [1:0] expv);
    exp_q.push_back(expv);
    event_signal = ev;
    @(posedge clk);
    #1;
    check_out(tag, e, exp_q.pop_front());
  endtask

  // Leaves the bench at a falling edge with reset released; next rising edge is edge 0.
  task automatic do_reset();
    event_signal = '0;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", -1, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;

    // Single event at edge 1, then a second event right after the gap ends.
    do_reset();
    for (int e = 0; e <= 40; e++)
      step("single", e, {1'b0, (e == 1) || (e == 20)},
           {1'b0, rng(e, 2, 11) || rng(e, 21, 31)});

    // Retrigger during ON extends the pulse.
    do_reset();
    for (int e = 0; e <= 28; e++)
      step("retrigger", e, {1'b0, (e == 1) || (e == 9)}, {1'b0, rng(e, 2, 19)});

    // Events during GAP collapse into a single blink after the gap.
    do_reset();
    for (int e = 0; e <= 44; e++)
      step("pending", e, {1'b0, (e == 1) || (e == 13) || (e == 15)},
           {1'b0, rng(e, 2, 11) || rng(e, 20, 31)});

    // Held input keeps the output high; expiry follows the third tick after release.
    do_reset();
    for (int e = 0; e <= 60; e++)
      step("held", e, {1'b0, rng(e, 1, 40)}, {1'b0, rng(e, 2, 51)});

    // Two independent channels with different event phases.
    do_reset();
    for (int e = 0; e <= 24; e++)
      step("two_chan", e, {(e == 5), (e == 1)}, {rng(e, 6, 15), rng(e, 2, 11)});

    // Asynchronous reset mid-ON, then silence afterwards.
    do_reset();
    for (int e = 0; e <= 6; e++)
      step("pre_reset_on", e, {1'b0, (e == 1)}, {1'b0, rng(e, 2, 6)});
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_mid_on", 7, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 20; e++)
      step("post_reset", e, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
